// File: rtl/ip_rx.sv
// IPv4 receive filter: parses Ethernet + IPv4 header from the MAC byte
// stream and forwards the payload of frames addressed to this station.
module ip_rx #(
  parameter int MIN_TOTAL_LEN = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_valid,
  input  logic        mac_rx_sof,
  input  logic        mac_rx_eof,
  output logic [7:0]  ip_rx_data,
  output logic        ip_rx_valid,
  output logic        ip_rx_start,
  output logic        ip_rx_end,
  output logic        ip_rx_error,
  output logic [7:0]  ip_rx_type,
  output logic [15:0] ip_rx_length,
  output logic [31:0] ip_rx_src_ip,
  output logic [47:0] ip_rx_src_mac,
  output logic [7:0]  ip_rx_ttl
);

  typedef enum logic [2:0] {
    IDLE, MAC_HDR, IP_HDR, PAYLOAD, DROP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic        uc_q, uc_d;
  logic        bc_q, bc_d;
  logic [15:0] tl_q, tl_d;
  logic [7:0]  proto_s_q, proto_s_d;
  logic [7:0]  ttl_s_q, ttl_s_d;
  logic [31:0] sip_s_q, sip_s_d;
  logic [47:0] smac_s_q, smac_s_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic        err_q, err_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] len_q, len_d;
  logic [31:0] sip_q, sip_d;
  logic [47:0] smac_q, smac_d;
  logic [7:0]  ttl_q, ttl_d;

  logic        hdr;
  logic        bad;
  logic [15:0] idx;
  logic [2:0]  mk;
  logic [7:0]  mac_b;
  logic [7:0]  ip_b;
  logic [16:0] s1;
  logic [15:0] s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      uc_q      <= 1'b0;
      bc_q      <= 1'b0;
      tl_q      <= '0;
      proto_s_q <= '0;
      ttl_s_q   <= '0;
      sip_s_q   <= '0;
      smac_s_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      type_q    <= '0;
      len_q     <= '0;
      sip_q     <= '0;
      smac_q    <= '0;
      ttl_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      uc_q      <= uc_d;
      bc_q      <= bc_d;
      tl_q      <= tl_d;
      proto_s_q <= proto_s_d;
      ttl_s_q   <= ttl_s_d;
      sip_s_q   <= sip_s_d;
      smac_s_q  <= smac_s_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      end_q     <= end_d;
      err_q     <= err_d;
      type_q    <= type_d;
      len_q     <= len_d;
      sip_q     <= sip_d;
      smac_q    <= smac_d;
      ttl_q     <= ttl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    uc_d      = uc_q;
    bc_d      = bc_q;
    tl_d      = tl_q;
    proto_s_d = proto_s_q;
    ttl_s_d   = ttl_s_q;
    sip_s_d   = sip_s_q;
    smac_s_d  = smac_s_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    type_d    = type_q;
    len_d     = len_q;
    sip_d     = sip_q;
    smac_d    = smac_q;
    ttl_d     = ttl_q;
    hdr       = 1'b0;
    bad       = 1'b0;
    idx       = cnt_q;
    s1        = '0;
    s2        = '0;

    // A sof byte always restarts parsing, whatever state we are in
    if (mac_rx_valid && mac_rx_sof) begin
      hdr = 1'b1;
      idx = '0;
    end else if (mac_rx_valid) begin
      hdr = (state_q == MAC_HDR) || (state_q == IP_HDR);
    end

    mk    = (idx[2:0] > 3'd5) ? 3'd0 : 3'd5 - idx[2:0];
    mac_b = local_mac_addr[{mk, 3'b000} +: 8];
    ip_b  = local_ip_addr[{2'd1 - idx[1:0], 3'b000} +: 8];

    if (hdr) begin
      if (mac_rx_sof) begin
        acc_d = '0;
        err_d = (state_q == PAYLOAD);
      end
      cnt_d   = idx + 16'd1;
      state_d = (idx < 16'd13) ? MAC_HDR : IP_HDR;
      hi_d    = mac_rx_data;
      if (idx[0] && idx >= 16'd15)
        acc_d = acc_q + {4'b0, hi_q, mac_rx_data};

      unique case (1'b1)
        idx < 16'd6: begin
          uc_d = ((idx == 16'd0) ? 1'b1 : uc_q)
               & (mac_rx_data == mac_b);
          bc_d = ((idx == 16'd0) ? 1'b1 : bc_q)
               & (mac_rx_data == 8'hFF);
          bad  = !(uc_d || bc_d);
        end
        (idx >= 16'd6 && idx < 16'd12):
          smac_s_d = {smac_s_q[39:0], mac_rx_data};
        idx == 16'd12: bad = (mac_rx_data != 8'h08);
        idx == 16'd13: bad = (mac_rx_data != 8'h00);
        idx == 16'd14: bad = (mac_rx_data != 8'h45);
        idx == 16'd17: begin
          tl_d = {hi_q, mac_rx_data};
          bad  = (tl_d < 16'(MIN_TOTAL_LEN));
        end
        idx == 16'd20: bad = (mac_rx_data[5:0] != 6'd0);
        idx == 16'd21: bad = (mac_rx_data != 8'h00);
        idx == 16'd22: ttl_s_d = mac_rx_data;
        idx == 16'd23: proto_s_d = mac_rx_data;
        (idx >= 16'd26 && idx < 16'd30):
          sip_s_d = {sip_s_q[23:0], mac_rx_data};
        (idx >= 16'd30 && idx < 16'd34):
          bad = (mac_rx_data != ip_b);
        default: ;
      endcase

      if (idx == 16'd33) begin
        s1 = {1'b0, acc_d[15:0]} + {13'b0, acc_d[19:16]};
        s2 = s1[15:0] + {15'b0, s1[16]};
        if (s2 != 16'hFFFF)
          bad = 1'b1;
        if (!bad && !mac_rx_eof) begin
          start_d = 1'b1;
          type_d  = proto_s_q;
          ttl_d   = ttl_s_q;
          sip_d   = sip_s_q;
          smac_d  = smac_s_q;
          len_d   = tl_q - 16'd20;
          cnt_d   = len_d;
          end_d   = (len_d == 16'd0);
          state_d = (len_d == 16'd0) ? DROP : PAYLOAD;
        end
      end

      if (bad)
        state_d = DROP;
      if (mac_rx_eof)
        state_d = IDLE;
    end else if (mac_rx_valid && state_q == PAYLOAD) begin
      data_d  = mac_rx_data;
      valid_d = 1'b1;
      cnt_d   = cnt_q - 16'd1;
      if (cnt_q == 16'd1) begin
        end_d   = 1'b1;
        state_d = mac_rx_eof ? IDLE : DROP;
      end else if (mac_rx_eof) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end else if (mac_rx_valid && state_q == DROP) begin
      if (mac_rx_eof)
        state_d = IDLE;
    end
  end

  assign ip_rx_data    = data_q;
  assign ip_rx_valid   = valid_q;
  assign ip_rx_start   = start_q;
  assign ip_rx_end     = end_q;
  assign ip_rx_error   = err_q;
  assign ip_rx_type    = type_q;
  assign ip_rx_length  = len_q;
  assign ip_rx_src_ip  = sip_q;
  assign ip_rx_src_mac = smac_q;
  assign ip_rx_ttl     = ttl_q;

endmodule
